sigmoid_inv: RTL and testbench

- Sequential inverse-sigmoid (logit) unit. Given a Q4.12 probability y, it returns the Q4.12 signed x for which sigmoid(x) best matches y.
- Uses a 16-step successive-approximation search over x. Each step evaluates the existing combinational `sigmoid` module (ports x, y).
- Sits beside `sigmoid` in the activation datapath. Provides the reverse direction for calibration and for the error-measurement flow.

---
 rtl/sigmoid_pkg.sv | 11 +
 rtl/sigmoid_inv_if.sv | 8 +
 rtl/sigmoid.sv | 17 +
 rtl/sigmoid_inv.sv | 66 ++++++
 tb/tb_sigmoid_inv.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: Q4.12 word type, constants and controller states shared by the sigmoid datapath.
package sigmoid_pkg;
    localparam int W = 16;
    localparam int FRAC = 12;
    typedef logic [W-1:0] fix_t;
    localparam fix_t X_MIN = 16'h8000;
    localparam fix_t X_MAX = 16'h7FFF;
    localparam fix_t ONE = fix_t'(1 << FRAC);
    localparam fix_t HALF = 16'h0800;
    typedef enum logic [1:0] {IDLE, SEARCH, SATCHK, DONE} state_t;
endpackage

// File: rtl/sigmoid_inv_if.sv
// sigmoid_inv_if: request/response handshake bundle of the inverse-sigmoid unit.
interface sigmoid_inv_if;
    import sigmoid_pkg::*;
    logic in_valid, in_ready, out_valid, out_ready, out_sat_lo, out_sat_hi;
    fix_t in_y, out_x;
    modport slave (input in_valid, in_y, out_ready, output in_ready, out_valid, out_x, out_sat_lo, out_sat_hi);
    modport master (output in_valid, in_y, out_ready, input in_ready, out_valid, out_x, out_sat_lo, out_sat_hi);
endinterface

// File: rtl/sigmoid.sv
// sigmoid: combinational piecewise-linear Q4.12 sigmoid, monotonic, output clamped to [1, ONE-1].
module sigmoid import sigmoid_pkg::*; (
    input  fix_t x,
    output fix_t y
);
    fix_t a, s0, s1, s2, m0, m1, f, r;
    assign a = x[W-1] ? fix_t'(-x) : x;
    // concave curve on |x| is the minimum of its line segments, which keeps it monotonic
    assign s0 = (a >> 2) + HALF;
    assign s1 = (a >> 3) + 16'h0A00;
    assign s2 = (a >> 5) + 16'h0D80;
    assign m0 = s0 < s1 ? s0 : s1;
    assign m1 = s2 < ONE ? s2 : ONE;
    assign f = m0 < m1 ? m0 : m1;
    assign r = x[W-1] ? ONE - f : f;
    assign y = r == '0 ? fix_t'(1) : (r >= ONE ? ONE - fix_t'(1) : r);
endmodule

// File: rtl/sigmoid_inv.sv
// sigmoid_inv: successive-approximation logit, finds the largest x with sigmoid(x) <= y.
module sigmoid_inv import sigmoid_pkg::*; #(
    parameter int SIG_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    sigmoid_inv_if.slave bus
);
    state_t state_q;
    fix_t y_q, u_q, sig_q, out_x_q, u_t, x_t, sig_y, sig_v;
    logic [3:0] k_q;
    logic ph_q, lo_q, hi_q, step;
    // search runs in offset binary so an unsigned bitwise search orders signed x correctly
    assign u_t = u_q | (fix_t'(1) << k_q);
    assign x_t = state_q == SATCHK ? X_MIN : u_t ^ X_MIN;
    sigmoid u_sig (.x(x_t), .y(sig_y));
    assign sig_v = SIG_LAT != 0 ? sig_q : sig_y;
    assign step = SIG_LAT == 0 || ph_q;
    assign bus.in_ready = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_x = out_x_q;
    assign bus.out_sat_lo = lo_q;
    assign bus.out_sat_hi = hi_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q <= '0;
            u_q <= '0;
            k_q <= '0;
            ph_q <= 1'b0;
            sig_q <= '0;
            out_x_q <= '0;
            lo_q <= 1'b0;
            hi_q <= 1'b0;
        end else begin
            sig_q <= sig_y;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    y_q <= bus.in_y;
                    u_q <= '0;
                    k_q <= 4'(W - 1);
                    ph_q <= 1'b0;
                    state_q <= SEARCH;
                end
                SEARCH: begin
                    ph_q <= !step;
                    if (step) begin
                        if (sig_v <= y_q) u_q <= u_t;
                        k_q <= k_q - 4'd1;
                        if (k_q == 4'd0) state_q <= SATCHK;
                    end
                end
                SATCHK: begin
                    ph_q <= !step;
                    if (step) begin
                        out_x_q <= u_q ^ X_MIN;
                        hi_q <= (u_q ^ X_MIN) == X_MAX;
                        lo_q <= u_q == '0 && sig_v > y_q;
                        state_q <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sigmoid_inv.sv
// tb_sigmoid_inv: directed and random checks of sigmoid_inv for SIG_LAT 0 and 1 against a largest-x reference.
module tb_sigmoid_inv;
    import sigmoid_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv [2], orr [2], ir [2], ov [2], lo_o [2], hi_o [2];
    fix_t iy [2], ox [2];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    sigmoid_inv_if b0 ();
    sigmoid_inv_if b1 ();
    assign b0.in_valid = iv[0];
    assign b0.in_y = iy[0];
    assign b0.out_ready = orr[0];
    assign ir[0] = b0.in_ready;
    assign ov[0] = b0.out_valid;
    assign ox[0] = b0.out_x;
    assign lo_o[0] = b0.out_sat_lo;
    assign hi_o[0] = b0.out_sat_hi;
    assign b1.in_valid = iv[1];
    assign b1.in_y = iy[1];
    assign b1.out_ready = orr[1];
    assign ir[1] = b1.in_ready;
    assign ov[1] = b1.out_valid;
    assign ox[1] = b1.out_x;
    assign lo_o[1] = b1.out_sat_lo;
    assign hi_o[1] = b1.out_sat_hi;
    sigmoid_inv #(.SIG_LAT(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    sigmoid_inv #(.SIG_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // reference curve in plain integer arithmetic on the signed value
    function automatic int sig(input fix_t x);
        int v, a, f, r;
        v = int'($signed(x));
        a = v < 0 ? -v : v;
        f = 4096;
        if (a / 4 + 2048 < f) f = a / 4 + 2048;
        if (a / 8 + 2560 < f) f = a / 8 + 2560;
        if (a / 32 + 3456 < f) f = a / 32 + 3456;
        r = v < 0 ? 4096 - f : f;
        return r < 1 ? 1 : (r > 4095 ? 4095 : r);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prop(input string tag, input int y, input fix_t x, input logic lo, input logic hi);
        int ehi, elo;
        ehi = int'(sig(X_MAX) <= y);
        elo = int'(sig(X_MIN) > y);
        chk({tag, "_hi"}, int'(hi), ehi);
        chk({tag, "_lo"}, int'(lo), elo);
        if (ehi != 0) chk({tag, "_xmax"}, int'(x), int'(X_MAX));
        else if (elo != 0) chk({tag, "_xmin"}, int'(x), int'(X_MIN));
        else chk({tag, "_largest"}, int'(sig(x) <= y && sig(x + 16'd1) > y), 1);
    endtask

    task automatic xact(input int s, input fix_t y, input int stall,
                        output fix_t x, output logic lo, output logic hi, output int lat);
        int n;
        n = 0;
        while (!ir[s] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        iy[s] = y;
        iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        lat = 0;
        while (!ov[s] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        x = ox[s];
        lo = lo_o[s];
        hi = hi_o[s];
        for (int i = 0; i < stall; i++) begin
            iv[s] = i[0];
            iy[s] = fix_t'($urandom);
            @(posedge clk); #1;
            chk("hold_x", int'(ox[s]), int'(x));
            chk("hold_flags", int'({lo_o[s], hi_o[s]}), int'({lo, hi}));
            chk("hold_valid", int'(ov[s]), 1);
            chk("hold_ready", int'(ir[s]), 0);
        end
        iv[s] = 1'b0;
        orr[s] = 1'b1;
        @(posedge clk); #1;
        orr[s] = 1'b0;
        chk("post_valid", int'(ov[s]), 0);
        chk("post_ready", int'(ir[s]), 1);
    endtask

    initial begin
        fix_t x, y;
        logic lo, hi;
        int lat, n;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0;
            orr[s] = 1'b0;
            iy[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", int'(ir[s]), 1);
            chk("rst_valid", int'(ov[s]), 0);
            chk("rst_x", int'(ox[s]), 0);
            chk("rst_flags", int'({lo_o[s], hi_o[s]}), 0);
        end
        xact(0, 16'h0800, 0, x, lo, hi, lat);
        chk("half_lat", lat, 17);
        prop("half", 'h0800, x, lo, hi);
        chk("half_flags", int'({lo, hi}), 0);
        xact(0, 16'h1000, 0, x, lo, hi, lat);
        chk("one_x", int'(x), 'h7FFF);
        chk("one_flags", int'({lo, hi}), 1);
        xact(0, 16'hFFFF, 0, x, lo, hi, lat);
        chk("ffff_x", int'(x), 'h7FFF);
        chk("ffff_flags", int'({lo, hi}), 1);
        xact(0, 16'h0000, 0, x, lo, hi, lat);
        chk("zero_x", int'(x), 'h8000);
        chk("zero_flags", int'({lo, hi}), 2);
        y = fix_t'(sig(X_MIN));
        xact(0, y, 0, x, lo, hi, lat);
        chk("floor_lo", int'(lo), 0);
        prop("floor", int'(y), x, lo, hi);
        xact(0, 16'h0A00, 10, x, lo, hi, lat);
        prop("bp", 'h0A00, x, lo, hi);
        iy[0] = 16'h0300;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", int'(ov[0]), 0);
        chk("arst_x", int'(ox[0]), 0);
        chk("arst_flags", int'({lo_o[0], hi_o[0]}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov[0]) n++;
        end
        chk("arst_no_valid", n, 0);
        xact(0, 16'h0C00, 0, x, lo, hi, lat);
        chk("after_rst_lat", lat, 17);
        prop("after_rst", 'h0C00, x, lo, hi);
        for (int i = 0; i < 200; i++) begin
            y = fix_t'($urandom);
            xact(0, y, $urandom_range(0, 2), x, lo, hi, lat);
            chk("r0_lat", lat, 17);
            prop("r0", int'(y), x, lo, hi);
        end
        for (int i = 0; i < 1200; i++) begin
            y = fix_t'($urandom_range(1, 4095));
            xact(1, y, $urandom_range(0, 3), x, lo, hi, lat);
            chk("r1_lat", lat, 34);
            prop("r1", int'(y), x, lo, hi);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
